// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the iterative shifter: op encodings (also used by the
// ALU control decoder), FSM state encodings and default widths.
package seq_shifter_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SAW   = 5;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_ROR = 2'b10,
        SH_SRA = 2'b11
    } sh_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/seq_shifter_step.sv
// Combinational single-bit shift of a WIDTH-bit value, selected by op.
module seq_shifter_step
    import seq_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  sh_op_e           op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_c
);

    always_comb begin
        q_c = d;
        case (op)
            SH_SLL:  q_c = {d[WIDTH-2:0], 1'b0};
            SH_SRL:  q_c = {1'b0, d[WIDTH-1:1]};
            SH_SRA:  q_c = {d[WIDTH-1], d[WIDTH-1:1]};
            SH_ROR:  q_c = {d[0], d[WIDTH-1:1]};
            default: q_c = d;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Iterative one-bit-per-clock shift unit (sll/srl/sra/ror) with a start/done
// handshake; result is held in its own register between operations.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SAW   = DEF_SAW
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic [SAW-1:0]   sa,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e           state,  state_n;
    sh_op_e           op_q,   op_n;
    logic [WIDTH-1:0] sreg,   sreg_n;
    logic [SAW-1:0]   count,  count_n;
    logic [WIDTH-1:0] result_n;
    logic [WIDTH-1:0] step_q;

    seq_shifter_step #(.WIDTH(WIDTH)) u_step (
        .op  (op_q),
        .d   (sreg),
        .q_c (step_q)
    );

    // Next-state and datapath; result only loads on the transition into DONE.
    always_comb begin
        state_n  = state;
        op_n     = op_q;
        sreg_n   = sreg;
        count_n  = count;
        result_n = result;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sreg_n  = d;
                    op_n    = sh_op_e'(op);
                    count_n = sa;
                    if (sa == SAW'(0)) begin
                        state_n  = S_DONE;
                        result_n = d;
                    end else begin
                        state_n = S_SHIFT;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_SHIFT: begin
                sreg_n  = step_q;
                count_n = count - SAW'(1);
                if (count == SAW'(1)) begin
                    state_n  = S_DONE;
                    result_n = step_q;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // busy/done are registered decodes of the next state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= S_IDLE;
            op_q   <= SH_SLL;
            sreg   <= '0;
            count  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            sreg   <= sreg_n;
            count  <= count_n;
            result <= result_n;
            busy   <= (state_n == S_SHIFT);
            done   <= (state_n == S_DONE);
        end
    end

endmodule
